// File: rtl/traffic_phase_timer_pkg.sv
// Shared traffic-light definitions: reset durations, config address map
// and the phase-vector helpers used by the light FSM and the phase timer.
package traffic_phase_timer_pkg;

    localparam int DUR_GREEN_RST  = 30;
    localparam int DUR_YELLOW_RST = 3;
    localparam int DUR_RED_RST    = 2;
    localparam int PED_MIN_DEF    = 5;

    typedef enum logic [1:0] {
        CFG_GREEN  = 2'd0,
        CFG_YELLOW = 2'd1,
        CFG_RED    = 2'd2,
        CFG_RSVD   = 2'd3
    } cfg_addr_e;

    typedef struct packed {
        logic green;
        logic yellow;
        logic red;
    } phase_t;

    function automatic logic phase_valid(input phase_t p);
        return $onehot(p);
    endfunction

endpackage

// File: rtl/traffic_phase_timer_down_counter.sv
// Seconds down-counter for the active phase: load, tick decrement and
// terminal-count detect (expire is combinational, registered by the caller).
module phase_down_counter #(
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             hold,
    input  logic             tick,
    output logic [DUR_W-1:0] cnt,
    output logic             expire
);

    logic dec;

    // A load always wins over a coincident tick; hold freezes the count.
    assign dec    = !load && !hold && tick && (cnt != '0);
    assign expire = dec && (cnt == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - DUR_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic-light FSM: per-phase programmable durations,
// entry detection, pedestrian shortening of green and expiry pulses.
module traffic_phase_timer
    import traffic_phase_timer_pkg::*;
#(
    parameter int DUR_W   = 8,
    parameter int PED_MIN = PED_MIN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             state_green,
    input  logic             state_yellow,
    input  logic             state_red,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [DUR_W-1:0] cfg_data,
    input  logic             ped_req,
    output logic             green_end,
    output logic             yellow_end,
    output logic             red_end,
    output logic [DUR_W-1:0] cnt_remain,
    output logic             ped_pending,
    output logic             cfg_err,
    output logic             state_err
);

    localparam logic [DUR_W-1:0] PED_MIN_V = DUR_W'(PED_MIN);

    phase_t           phase;
    phase_t           prev;
    logic             valid;
    logic             entry;
    logic [DUR_W-1:0] dur_green;
    logic [DUR_W-1:0] dur_yellow;
    logic [DUR_W-1:0] dur_red;
    logic [DUR_W-1:0] cfg_val;
    logic [DUR_W-1:0] entry_dur;
    logic             ped_short;
    logic             ped_short_done;
    logic             cnt_load;
    logic [DUR_W-1:0] cnt_load_val;
    logic             expire;

    assign phase = {state_green, state_yellow, state_red};
    assign valid = phase_valid(phase);
    assign entry = valid && (phase != prev);

    // prev only tracks valid vectors so a glitch back to the same phase is not an entry
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (valid) begin
            prev <= phase;
        end
    end

    assign cfg_val = (cfg_data == '0) ? DUR_W'(1) : cfg_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            dur_green  <= DUR_W'(DUR_GREEN_RST);
            dur_yellow <= DUR_W'(DUR_YELLOW_RST);
            dur_red    <= DUR_W'(DUR_RED_RST);
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_we && ((cfg_addr == CFG_RSVD) || (cfg_data == '0));
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_GREEN:  dur_green  <= cfg_val;
                    CFG_YELLOW: dur_yellow <= cfg_val;
                    CFG_RED:    dur_red    <= cfg_val;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        entry_dur = dur_red;
        if (phase.green) begin
            entry_dur = dur_green;
        end else if (phase.yellow) begin
            entry_dur = dur_yellow;
        end
    end

    // ped_req is folded in directly so the shortening lands the cycle after the request
    assign ped_short = valid && !entry && phase.green && !ped_short_done
                     && (ped_pending || ped_req) && (cnt_remain > PED_MIN_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending    <= 1'b0;
            ped_short_done <= 1'b0;
        end else begin
            if (ped_req) begin
                ped_pending <= 1'b1;
            end else if (entry && phase.red) begin
                ped_pending <= 1'b0;
            end
            if (entry) begin
                ped_short_done <= 1'b0;
            end else if (ped_short) begin
                ped_short_done <= 1'b1;
            end
        end
    end

    assign cnt_load     = entry || ped_short;
    assign cnt_load_val = entry ? entry_dur : PED_MIN_V;

    phase_down_counter #(
        .DUR_W (DUR_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .hold     (!valid),
        .tick     (tick),
        .cnt      (cnt_remain),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            green_end  <= 1'b0;
            yellow_end <= 1'b0;
            red_end    <= 1'b0;
            state_err  <= 1'b0;
        end else begin
            green_end  <= expire && phase.green;
            yellow_end <= expire && phase.yellow;
            red_end    <= expire && phase.red;
            state_err  <= !valid;
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: a per-cycle behavioural model
// compared on every falling edge, plus hand-computed literal checkpoints.
module tb_traffic_phase_timer;

    localparam int DUR_W   = 8;
    localparam int PED_MIN = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             state_green;
    logic             state_yellow;
    logic             state_red;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [DUR_W-1:0] cfg_data;
    logic             ped_req;
    logic             green_end;
    logic             yellow_end;
    logic             red_end;
    logic [DUR_W-1:0] cnt_remain;
    logic             ped_pending;
    logic             cfg_err;
    logic             state_err;

    int n_checks = 0;
    int n_errors = 0;

    traffic_phase_timer #(
        .DUR_W   (DUR_W),
        .PED_MIN (PED_MIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .state_green  (state_green),
        .state_yellow (state_yellow),
        .state_red    (state_red),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .ped_req      (ped_req),
        .green_end    (green_end),
        .yellow_end   (yellow_end),
        .red_end      (red_end),
        .cnt_remain   (cnt_remain),
        .ped_pending  (ped_pending),
        .cfg_err      (cfg_err),
        .state_err    (state_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: phase index 0=green 1=yellow 2=red, -1 = no valid phase seen
    int m_cnt;
    int m_dur [3];
    int m_prev;
    bit m_ped;
    bit m_short;
    bit m_cfgerr;
    bit m_err;
    bit m_end [3];
    bit m_valid = 1'b0;
    int m_n;
    int m_idx;
    bit m_entry;

    always @(posedge clk) begin
        m_n   = int'(state_green) + int'(state_yellow) + int'(state_red);
        m_idx = state_green ? 0 : (state_yellow ? 1 : 2);
        if (rst) begin
            m_valid  = 1'b1;
            m_cnt    = 0;
            m_dur    = '{30, 3, 2};
            m_prev   = -1;
            m_ped    = 1'b0;
            m_short  = 1'b0;
            m_cfgerr = 1'b0;
            m_err    = 1'b0;
            m_end    = '{1'b0, 1'b0, 1'b0};
        end else begin
            m_end    = '{1'b0, 1'b0, 1'b0};
            m_err    = (m_n != 1);
            m_cfgerr = cfg_we && (cfg_addr == 2'd3 || cfg_data == '0);
            m_entry  = (m_n == 1) && (m_idx != m_prev);
            if (m_entry) begin
                m_cnt   = m_dur[m_idx];
                m_short = 1'b0;
            end else if (m_n == 1) begin
                if (m_idx == 0 && (m_ped || ped_req) && !m_short && m_cnt > PED_MIN) begin
                    m_cnt   = PED_MIN;
                    m_short = 1'b1;
                end else if (tick && m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_end[m_idx] = 1'b1;
                end
            end
            if (ped_req) m_ped = 1'b1;
            else if (m_entry && m_idx == 2) m_ped = 1'b0;
            if (m_n == 1) m_prev = m_idx;
            if (cfg_we && cfg_addr != 2'd3) m_dur[cfg_addr] = (cfg_data == '0) ? 1 : int'(cfg_data);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_cnt_remain", int'(cnt_remain), m_cnt);
            chk("model_green_end", int'(green_end), int'(m_end[0]));
            chk("model_yellow_end", int'(yellow_end), int'(m_end[1]));
            chk("model_red_end", int'(red_end), int'(m_end[2]));
            chk("model_ped_pending", int'(ped_pending), int'(m_ped));
            chk("model_cfg_err", int'(cfg_err), int'(m_cfgerr));
            chk("model_state_err", int'(state_err), int'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        tick     = 1'b0;
        ped_req  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = '0;
    endtask

    task automatic set_ph(input logic [2:0] ph);
        {state_green, state_yellow, state_red} = ph;
    endtask

    task automatic tick_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
    endtask

    int pulses;

    initial begin
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = '0;
        set_ph(3'b000);
        cyc(); cyc();
        chk("reset_cnt", int'(cnt_remain), 0);
        chk("reset_state_err", int'(state_err), 0);

        // red straight out of reset, two ticks to expiry
        rst = 1'b0; set_ph(3'b001);
        cyc();
        chk("red_entry_cnt", int'(cnt_remain), 2);
        tick_cyc(1);
        chk("red_cnt_1", int'(cnt_remain), 1);
        chk("red_end_early", int'(red_end), 0);
        tick_cyc(1);
        chk("red_cnt_0", int'(cnt_remain), 0);
        chk("red_end_pulse", int'(red_end), 1);
        cyc();
        chk("red_end_once", int'(red_end), 0);
        tick_cyc(2);
        chk("red_no_repeat", int'(red_end), 0);

        // green entry with coincident tick loads the full duration
        set_ph(3'b100); tick = 1'b1;
        cyc();
        chk("green_entry_cnt", int'(cnt_remain), 30);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick_cyc(1);
            pulses += int'(green_end);
        end
        chk("green_end_count", pulses, 1);
        chk("green_end_last", int'(green_end), 1);

        set_ph(3'b010);
        cyc();
        chk("yellow_entry_cnt", int'(cnt_remain), 3);
        tick_cyc(3);
        chk("yellow_end_pulse", int'(yellow_end), 1);

        set_ph(3'b001);
        cyc();
        set_ph(3'b100);
        cyc();
        tick_cyc(10);
        chk("green_cnt_20", int'(cnt_remain), 20);
        ped_req = 1'b1;
        cyc();
        chk("ped_short_cnt", int'(cnt_remain), 5);
        chk("ped_pending_set", int'(ped_pending), 1);

        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = '0;
        cyc();
        chk("cfg_zero_err", int'(cfg_err), 1);
        chk("cfg_no_effect", int'(cnt_remain), 5);
        tick_cyc(5);
        chk("ped_green_end", int'(green_end), 1);

        set_ph(3'b010);
        cyc();
        chk("yellow_clamped", int'(cnt_remain), 1);
        tick_cyc(1);
        chk("yellow_clamped_end", int'(yellow_end), 1);

        set_ph(3'b001);
        cyc();
        chk("ped_cleared_red", int'(ped_pending), 0);

        // invalid vectors freeze the count; return to the same phase is not an entry
        set_ph(3'b100);
        cyc();
        tick_cyc(2);
        set_ph(3'b101);
        tick_cyc(3);
        chk("invalid_err", int'(state_err), 1);
        chk("invalid_frozen", int'(cnt_remain), 28);
        set_ph(3'b000);
        tick_cyc(1);
        chk("zero_vec_frozen", int'(cnt_remain), 28);
        set_ph(3'b100);
        tick_cyc(1);
        chk("resume_err_clr", int'(state_err), 0);
        chk("resume_no_reload", int'(cnt_remain), 27);

        // reset on the expiring tick of yellow
        set_ph(3'b010);
        cyc();
        chk("yellow_pre_rst", int'(cnt_remain), 1);
        rst = 1'b1; tick = 1'b1;
        cyc();
        chk("rst_no_yellow_end", int'(yellow_end), 0);
        chk("rst_cnt", int'(cnt_remain), 0);
        rst = 1'b0;
        cyc();
        chk("rst_yellow_dur", int'(cnt_remain), 3);

        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd7;
        cyc();
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 8'd9;
        cyc();
        chk("cfg_rsvd_err", int'(cfg_err), 1);
        set_ph(3'b100);
        cyc();
        chk("green_new_dur", int'(cnt_remain), 7);
        ped_req = 1'b1;
        cyc();
        chk("ped_short_7", int'(cnt_remain), 5);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
